// File: rtl/vending_machine_param.sv
`default_nettype none
// ============================================================================
// Module   : vending_machine_param
// Purpose  : ROWS x COLS vending controller with programmable prices, stock
//            counters, inactivity refund and one-coin-per-cycle change payout.
// Revision : 1.0  initial release
// ============================================================================
module vending_machine_param #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int MONEY_W       = 16,
    parameter int COIN_UNIT     = 25,
    parameter int PRICE_DEFAULT = 100,
    parameter int STOCK_W       = 4,
    parameter int STOCK_INIT    = 5,
    parameter int TIMEOUT_CYC   = 1000,
    parameter int SEL_W         = $clog2(ROWS*COLS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    input  logic [ROWS-1:0]    row_sel,
    input  logic [COLS-1:0]    col_sel,
    input  logic               cancel,
    input  logic               restock,
    input  logic               prog_we,
    input  logic [SEL_W-1:0]   prog_addr,
    input  logic [MONEY_W-1:0] prog_price,
    output logic [MONEY_W-1:0] credit,
    output logic [MONEY_W-1:0] price,
    output logic [SEL_W-1:0]   dispense,
    output logic               dispense_valid,
    output logic               success,
    output logic [MONEY_W-1:0] change,
    output logic               change_valid,
    output logic               insufficient,
    output logic               sold_out,
    output logic               key_error,
    output logic               coin_reject
);

    localparam int                 c_slots        = ROWS * COLS;
    localparam int                 c_timer_w      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SEL_W-1:0]   c_cols         = SEL_W'(COLS);
    localparam logic [MONEY_W-1:0] c_coin_unit    = MONEY_W'(COIN_UNIT);
    localparam logic [MONEY_W-1:0] c_price_def    = MONEY_W'(PRICE_DEFAULT);
    localparam logic [STOCK_W-1:0] c_stock_init   = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0] c_stock_one    = STOCK_W'(1);
    localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(TIMEOUT_CYC - 1);
    localparam logic [c_timer_w-1:0] c_timer_one    = c_timer_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROW_WAIT = 2'd1,
        ST_VEND     = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [MONEY_W-1:0]   r_credit, w_credit_nxt;
    logic [SEL_W-1:0]     r_row, w_row_nxt;
    logic [SEL_W-1:0]     r_slot, w_slot_nxt;
    logic [MONEY_W-1:0]   r_price, w_price_nxt;
    logic [c_timer_w-1:0] r_timer, w_timer_nxt;
    logic [SEL_W-1:0]     r_dispense, w_dispense_nxt;
    logic                 r_success, w_success_nxt;
    logic [MONEY_W-1:0]   r_change, w_change_nxt;
    logic                 r_change_valid, w_change_valid_nxt;
    logic                 r_insufficient, w_insufficient_nxt;
    logic                 r_sold_out, w_sold_out_nxt;
    logic                 r_key_error, w_key_error_nxt;
    logic                 r_coin_reject, w_coin_reject_nxt;
    logic                 w_vend_ok;

    logic [MONEY_W-1:0]   r_price_tbl [c_slots];
    logic [STOCK_W-1:0]   r_stock     [c_slots];

    logic                 w_coin;
    logic [MONEY_W:0]     w_coin_sum;
    logic                 w_row_any, w_col_any, w_key, w_activity;
    logic [SEL_W-1:0]     w_slot_sel;
    logic [MONEY_W-1:0]   w_vend_rem, w_change_amt, w_change_rem;

    function automatic logic [SEL_W-1:0] f_row_idx(input logic [ROWS-1:0] v);
        f_row_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) f_row_idx = SEL_W'(i);
        end
    endfunction

    function automatic logic [SEL_W-1:0] f_col_idx(input logic [COLS-1:0] v);
        f_col_idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (v[i]) f_col_idx = SEL_W'(i);
        end
    endfunction

    assign w_coin       = coin_valid && (coin_value != '0);
    assign w_coin_sum   = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_row_any    = |row_sel;
    assign w_col_any    = |col_sel;
    assign w_key        = w_row_any || w_col_any;
    assign w_activity   = w_coin || w_key || cancel;
    assign w_slot_sel   = r_row * c_cols + f_col_idx(col_sel);
    assign w_vend_rem   = r_credit - r_price;
    assign w_change_amt = (r_credit < c_coin_unit) ? r_credit : c_coin_unit;
    assign w_change_rem = r_credit - w_change_amt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_row          <= '0;
            r_slot         <= '0;
            r_price        <= '0;
            r_timer        <= '0;
            r_dispense     <= '0;
            r_success      <= 1'b0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
            r_insufficient <= 1'b0;
            r_sold_out     <= 1'b0;
            r_key_error    <= 1'b0;
            r_coin_reject  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_credit       <= w_credit_nxt;
            r_row          <= w_row_nxt;
            r_slot         <= w_slot_nxt;
            r_price        <= w_price_nxt;
            r_timer        <= w_timer_nxt;
            r_dispense     <= w_dispense_nxt;
            r_success      <= w_success_nxt;
            r_change       <= w_change_nxt;
            r_change_valid <= w_change_valid_nxt;
            r_insufficient <= w_insufficient_nxt;
            r_sold_out     <= w_sold_out_nxt;
            r_key_error    <= w_key_error_nxt;
            r_coin_reject  <= w_coin_reject_nxt;
        end
    end

    // The vending slot's price is latched in r_price, so a table write landing
    // during VEND only affects later selections.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < c_slots; i++) r_price_tbl[i] <= c_price_def;
        end else if (prog_we) begin
            r_price_tbl[prog_addr] <= prog_price;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || restock) begin
            for (int i = 0; i < c_slots; i++) r_stock[i] <= c_stock_init;
        end else if (w_vend_ok) begin
            r_stock[r_slot] <= r_stock[r_slot] - c_stock_one;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_credit_nxt       = r_credit;
        w_row_nxt          = r_row;
        w_slot_nxt         = r_slot;
        w_price_nxt        = r_price;
        w_timer_nxt        = '0;
        w_dispense_nxt     = '0;
        w_success_nxt      = 1'b0;
        w_change_nxt       = '0;
        w_change_valid_nxt = 1'b0;
        w_insufficient_nxt = 1'b0;
        w_sold_out_nxt     = 1'b0;
        w_key_error_nxt    = 1'b0;
        w_coin_reject_nxt  = 1'b0;
        w_vend_ok          = 1'b0;

        case (r_state)
            ST_IDLE, ST_ROW_WAIT: begin
                if (w_coin) begin
                    if (w_coin_sum[MONEY_W]) w_coin_reject_nxt = 1'b1;
                    else                     w_credit_nxt      = w_coin_sum[MONEY_W-1:0];
                end

                if (!w_activity && (r_credit != '0) && (r_timer != c_timeout_last))
                    w_timer_nxt = r_timer + c_timer_one;

                if (cancel && (r_credit != '0)) begin
                    w_state_nxt = ST_CHANGE;
                    w_row_nxt   = '0;
                end else if (w_key) begin
                    if (r_state == ST_IDLE && !w_col_any && $onehot(row_sel)) begin
                        w_row_nxt   = f_row_idx(row_sel);
                        w_state_nxt = ST_ROW_WAIT;
                    end else if (r_state == ST_ROW_WAIT && !w_row_any && $onehot(col_sel)) begin
                        w_slot_nxt  = w_slot_sel;
                        w_price_nxt = r_price_tbl[w_slot_sel];
                        w_state_nxt = ST_VEND;
                    end else begin
                        w_key_error_nxt = 1'b1;
                        w_row_nxt       = '0;
                        w_state_nxt     = ST_IDLE;
                    end
                end else if (!w_coin && (r_credit != '0) && (r_timer == c_timeout_last)) begin
                    w_state_nxt = ST_CHANGE;
                    w_row_nxt   = '0;
                end
            end

            ST_VEND: begin
                w_row_nxt   = '0;
                w_state_nxt = ST_IDLE;
                if (w_coin) w_coin_reject_nxt = 1'b1;
                if (r_stock[r_slot] == '0) begin
                    w_sold_out_nxt = 1'b1;
                end else if (r_credit < r_price) begin
                    w_insufficient_nxt = 1'b1;
                end else begin
                    w_vend_ok      = 1'b1;
                    w_success_nxt  = 1'b1;
                    w_dispense_nxt = r_slot;
                    w_credit_nxt   = w_vend_rem;
                    if (w_vend_rem != '0) w_state_nxt = ST_CHANGE;
                end
            end

            ST_CHANGE: begin
                if (w_coin) w_coin_reject_nxt = 1'b1;
                w_change_valid_nxt = 1'b1;
                w_change_nxt       = w_change_amt;
                w_credit_nxt       = w_change_rem;
                if (w_change_rem == '0) w_state_nxt = ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign credit         = r_credit;
    assign price          = r_price;
    assign dispense       = r_dispense;
    assign dispense_valid = r_success;
    assign success        = r_success;
    assign change         = r_change;
    assign change_valid   = r_change_valid;
    assign insufficient   = r_insufficient;
    assign sold_out       = r_sold_out;
    assign key_error      = r_key_error;
    assign coin_reject    = r_coin_reject;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_machine_param
// Purpose  : Scoreboard bench: stimulus queues expected output events, a
//            monitor pops and compares them whenever the DUT pulses an output.
// Revision : 1.0  initial release
// ============================================================================
module tb_vending_machine_param;

    localparam int c_to = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        coin_valid = 1'b0;
    logic [15:0] coin_value = '0;
    logic [3:0]  row_sel = '0;
    logic [3:0]  col_sel = '0;
    logic        cancel = 1'b0;
    logic        restock = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_price = '0;
    logic [15:0] credit, price, change;
    logic [3:0]  dispense;
    logic        dispense_valid, success, change_valid;
    logic        insufficient, sold_out, key_error, coin_reject;

    vending_machine_param #(
        .ROWS(4), .COLS(4), .MONEY_W(16), .COIN_UNIT(25), .PRICE_DEFAULT(100),
        .STOCK_W(4), .STOCK_INIT(5), .TIMEOUT_CYC(c_to)
    ) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
        .row_sel(row_sel), .col_sel(col_sel), .cancel(cancel), .restock(restock),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_price(prog_price),
        .credit(credit), .price(price), .dispense(dispense),
        .dispense_valid(dispense_valid), .success(success), .change(change),
        .change_valid(change_valid), .insufficient(insufficient),
        .sold_out(sold_out), .key_error(key_error), .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        succ;
        logic        dv;
        logic [3:0]  disp;
        logic        chg_v;
        logic [15:0] chg;
        logic        insuf;
        logic        sold;
        logic        kerr;
        logic        crej;
        logic [15:0] credit;
        logic [15:0] price;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_act, mon_exp;
    int  n_checks = 0;
    int  n_pass   = 0;

    function automatic string ev_str(ev_t e);
        return $sformatf("succ=%0b dv=%0b disp=%0d chg_v=%0b chg=%0d insuf=%0b sold=%0b kerr=%0b crej=%0b credit=%0d price=%0d",
                         e.succ, e.dv, e.disp, e.chg_v, e.chg, e.insuf, e.sold, e.kerr, e.crej, e.credit, e.price);
    endfunction

    function automatic void exp_success(logic [3:0] d, logic [15:0] cr, logic [15:0] pr);
        ev_t e = '0;
        e.succ = 1'b1; e.dv = 1'b1; e.disp = d; e.credit = cr; e.price = pr;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_change(logic [15:0] amt, logic [15:0] cr, logic [15:0] pr, logic rej);
        ev_t e = '0;
        e.chg_v = 1'b1; e.chg = amt; e.crej = rej; e.credit = cr; e.price = pr;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_pulse(logic ins, logic sld, logic ke, logic rej,
                                      logic [15:0] cr, logic [15:0] pr);
        ev_t e = '0;
        e.insuf = ins; e.sold = sld; e.kerr = ke; e.crej = rej; e.credit = cr; e.price = pr;
        exp_q.push_back(e);
    endfunction

    // Monitor: every cycle with any pulse consumes exactly one expected event.
    always @(negedge clk) begin
        if (reset && (success || dispense_valid || change_valid || insufficient ||
                      sold_out || key_error || coin_reject)) begin
            mon_act = '0;
            mon_act.succ = success;       mon_act.dv    = dispense_valid;
            mon_act.disp = dispense;      mon_act.chg_v = change_valid;
            mon_act.chg  = change;        mon_act.insuf = insufficient;
            mon_act.sold = sold_out;      mon_act.kerr  = key_error;
            mon_act.crej = coin_reject;   mon_act.credit = credit;
            mon_act.price = price;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got {%s} required no event", ev_str(mon_act));
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act === mon_exp) n_pass++;
                else $display("FAIL event: got {%s} required {%s}", ev_str(mon_act), ev_str(mon_exp));
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic coin(logic [15:0] v);
        coin_valid = 1'b1; coin_value = v;
        tick();
        coin_valid = 1'b0; coin_value = '0;
    endtask

    task automatic keys(logic [3:0] r, logic [3:0] c);
        row_sel = r; col_sel = c;
        tick();
        row_sel = '0; col_sel = '0;
    endtask

    task automatic prog(logic [3:0] a, logic [15:0] p);
        prog_we = 1'b1; prog_addr = a; prog_price = p;
        tick();
        prog_we = 1'b0; prog_addr = '0; prog_price = '0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic vend(int r, int c);
        logic [3:0] r_oh, c_oh;
        r_oh = 4'b0001 << r;
        c_oh = 4'b0001 << c;
        keys(r_oh, 4'b0000);
        keys(4'b0000, c_oh);
        ticks(2);
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_quiet(string tag);
        chk({tag, "_credit"}, credit, 0);
        chk({tag, "_price"}, price, 0);
        chk({tag, "_dispense"}, dispense, 0);
        chk({tag, "_pulses"}, {success, dispense_valid, change_valid, insufficient,
                               sold_out, key_error, coin_reject}, 0);
        chk({tag, "_change"}, change, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        ticks(3);
        reset = 1'b1;
        tick();
        check_quiet("reset");

        // T1: exact payment with quarters, A2 -> slot 1, no change.
        exp_success(4'd1, 16'd0, 16'd100);
        repeat (4) coin(16'd25);
        chk("t1_credit_100", credit, 100);
        vend(0, 1);
        drain("t1_drain", 10);
        chk("t1_credit_0", credit, 0);

        // T2: B4 with no credit, then coins accepted while in ROW_WAIT.
        prog(4'd7, 16'd175);
        exp_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd175);
        vend(1, 3);
        exp_success(4'd7, 16'd0, 16'd175);
        keys(4'b0010, 4'b0000);
        coin(16'd100);
        coin(16'd75);
        chk("t2_credit_rowwait", credit, 175);
        keys(4'b0000, 4'b1000);
        drain("t2_drain", 10);
        chk("t2_credit_0", credit, 0);

        // T3: overpay 200 for 150, change 25 then 25.
        prog(4'd2, 16'd150);
        exp_success(4'd2, 16'd50, 16'd150);
        exp_change(16'd25, 16'd25, 16'd150, 1'b0);
        exp_change(16'd25, 16'd0, 16'd150, 1'b0);
        coin(16'd100);
        coin(16'd100);
        vend(0, 2);
        drain("t3_drain", 10);
        chk("t3_credit_0", credit, 0);

        // T4: illegal key sequences keep credit; then cancel refunds all.
        coin(16'd100);
        coin(16'd100);
        repeat (5) exp_pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'd200, 16'd150);
        keys(4'b0001, 4'b0000);
        keys(4'b0001, 4'b0000);
        keys(4'b0000, 4'b1000);
        keys(4'b0001, 4'b0001);
        keys(4'b0011, 4'b0000);
        keys(4'b0010, 4'b0000);
        keys(4'b0000, 4'b0110);
        drain("t4_keyerr_drain", 10);
        chk("t4_credit_kept", credit, 200);
        for (int k = 1; k <= 8; k++) exp_change(16'd25, 16'(200 - 25 * k), 16'd150, 1'b0);
        do_cancel();
        drain("t4_cancel_drain", 20);
        chk("t4_credit_0", credit, 0);

        // T5: insufficient credit, then inactivity timeout refund.
        prog(4'd4, 16'd250);
        exp_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'd100, 16'd250);
        coin(16'd100);
        vend(1, 0);
        ticks(c_to - 6);
        chk("t5_no_early_timeout", credit, 100);
        for (int k = 1; k <= 4; k++) exp_change(16'd25, 16'(100 - 25 * k), 16'd250, 1'b0);
        drain("t5_timeout_drain", 30);
        chk("t5_credit_0", credit, 0);

        // T6: overflow reject, zero coin ignored, reset discards credit.
        exp_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'd65000, 16'd250);
        coin(16'd65000);
        coin(16'd1000);
        coin(16'd0);
        drain("t6_overflow_drain", 10);
        chk("t6_overflow_credit", credit, 65000);
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();
        check_quiet("midreset");

        // Free slot 0: five vends empty it, sixth is sold out, restock refills.
        prog(4'd0, 16'd0);
        for (int k = 0; k < 5; k++) exp_success(4'd0, 16'd0, 16'd0);
        exp_pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (6) vend(0, 0);
        drain("t6_soldout_drain", 10);
        restock = 1'b1;
        tick();
        restock = 1'b0;
        exp_success(4'd0, 16'd0, 16'd0);
        vend(0, 0);
        drain("t6_restock_drain", 10);

        // Coin arriving while change is being paid is rejected.
        exp_change(16'd25, 16'd25, 16'd0, 1'b1);
        exp_change(16'd25, 16'd0, 16'd0, 1'b0);
        coin(16'd50);
        do_cancel();
        coin(16'd25);
        drain("t6_change_reject_drain", 10);
        chk("t6_final_credit", credit, 0);

        ticks(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
